// File: rtl/regbank_pkg.sv
// Shared defaults and helpers for the multi-port register bank.
package regbank_pkg;

  localparam int DEF_N  = 32;
  localparam int DEF_M  = 32;
  localparam int DEF_NR = 2;
  localparam int DEF_NW = 2;

  // Address width needed to select one of m registers.
  function automatic int addr_w(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/regbank_wr_arb.sv
// Write-port arbitration: per-register enable/data with highest port winning,
// plus a flag raised when two or more enabled ports hit the same register.
module regbank_wr_arb
  import regbank_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int M        = DEF_M,
  parameter int NW       = DEF_NW,
  parameter int ZERO_REG = 1
) (
  input  logic [NW-1:0]            we,
  input  logic [NW*addr_w(M)-1:0]  waddr,
  input  logic [NW*N-1:0]          wdata,
  output logic [M-1:0]             reg_we,
  output logic [M*N-1:0]           reg_wdata,
  output logic                     collision
);

  localparam int AW = addr_w(M);

  logic [M-1:0] coll_vec;

  for (genvar gi = 0; gi < M; gi++) begin : g_reg
    if (ZERO_REG != 0 && gi == 0) begin : g_zero
      // Hardwired zero register: never written, never a collision.
      assign reg_we[gi]             = 1'b0;
      assign reg_wdata[gi*N +: N]   = '0;
      assign coll_vec[gi]           = 1'b0;
    end else begin : g_live
      logic [2:0]   hits;
      logic [N-1:0] win_data;
      logic         win_en;

      // Ports scanned in ascending order so the last match (highest index) wins.
      always_comb begin
        hits     = '0;
        win_data = '0;
        win_en   = 1'b0;
        for (int i = 0; i < NW; i++) begin
          if (we[i] && waddr[i*AW +: AW] == AW'(gi)) begin
            win_en   = 1'b1;
            win_data = wdata[i*N +: N];
            hits     = hits + 3'd1;
          end
        end
      end

      assign reg_we[gi]           = win_en;
      assign reg_wdata[gi*N +: N] = win_data;
      assign coll_vec[gi]         = (hits >= 3'd2);
    end
  end

  assign collision = |coll_vec;

endmodule

// File: rtl/mp_reg_bank.sv
// Multi-port register bank with optional write-first bypass, zero register,
// per-register busy scoreboard and a saturating write-collision counter.
module mp_reg_bank
  import regbank_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int M        = DEF_M,
  parameter int NR       = DEF_NR,
  parameter int NW       = DEF_NW,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NW-1:0]            we,
  input  logic [NW*addr_w(M)-1:0]  waddr,
  input  logic [NW*N-1:0]          wdata,
  input  logic [NR*addr_w(M)-1:0]  raddr,
  output logic [NR*N-1:0]          rdata,
  input  logic                     set_busy,
  input  logic [addr_w(M)-1:0]     busy_addr,
  output logic [NR-1:0]            rbusy,
  output logic [7:0]               coll_cnt
);

  localparam int AW = addr_w(M);

  logic [N-1:0]   regs_reg [M];
  logic [M-1:0]   busy_reg;
  logic [7:0]     coll_cnt_reg;
  logic [M-1:0]   reg_we;
  logic [M*N-1:0] reg_wdata;
  logic           collision;

  regbank_wr_arb #(
    .N        (N),
    .M        (M),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_wr_arb (
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .collision (collision)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < M; r++) regs_reg[r] <= '0;
      busy_reg     <= '0;
      coll_cnt_reg <= '0;
    end else begin
      for (int r = 0; r < M; r++) begin
        if (reg_we[r]) regs_reg[r] <= reg_wdata[r*N +: N];
        // Set takes priority over the write-driven clear.
        if (set_busy && busy_addr == r[AW-1:0] && !(ZERO_REG != 0 && r == 0))
          busy_reg[r] <= 1'b1;
        else if (reg_we[r])
          busy_reg[r] <= 1'b0;
      end
      if (collision && coll_cnt_reg != 8'hFF)
        coll_cnt_reg <= coll_cnt_reg + 8'd1;
    end
  end

  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    logic [AW-1:0] ra;
    logic [N-1:0]  rd;
    logic          rb;

    assign ra = raddr[gi*AW +: AW];

    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (rst) begin
        rb = busy_reg[ra];
        if (ZERO_REG != 0 && ra == '0)
          rd = '0;
        else if (BYPASS != 0 && reg_we[ra])
          rd = reg_wdata[ra*N +: N];
        else
          rd = regs_reg[ra];
      end
    end

    assign rdata[gi*N +: N] = rd;
    assign rbusy[gi]        = rb;
  end

  assign coll_cnt = coll_cnt_reg;

endmodule

// File: tb/tb_mp_reg_bank.sv
// Randomized + directed bench for mp_reg_bank: a write-first and a read-old
// instance share stimulus and are compared each cycle against an array model.
module tb_mp_reg_bank;

  localparam int N  = 32;
  localparam int M  = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NW-1:0]     we = '0;
  logic [NW*AW-1:0]  waddr = '0;
  logic [NW*N-1:0]   wdata = '0;
  logic [NR*AW-1:0]  raddr = '0;
  logic              set_busy = 1'b0;
  logic [AW-1:0]     busy_addr = '0;
  logic [NR*N-1:0]   rdata_b, rdata_o;
  logic [NR-1:0]     rbusy_b, rbusy_o;
  logic [7:0]        coll_b, coll_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mp_reg_bank #(.N(N), .M(M), .NR(NR), .NW(NW), .BYPASS(1), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .set_busy(set_busy), .busy_addr(busy_addr), .rbusy(rbusy_b),
    .coll_cnt(coll_b));

  mp_reg_bank #(.N(N), .M(M), .NR(NR), .NW(NW), .BYPASS(0), .ZERO_REG(1)) dut_o (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_o), .set_busy(set_busy), .busy_addr(busy_addr), .rbusy(rbusy_o),
    .coll_cnt(coll_o));

  // ---------------- behavioural model ----------------
  int unsigned mem [M];
  bit          mbusy [M];
  int          mcnt;

  function automatic int wa(int i);
    return int'(waddr[i*AW +: AW]);
  endfunction
  function automatic int unsigned wd(int i);
    return wdata[i*N +: N];
  endfunction
  function automatic int ra(int j);
    return int'(raddr[j*AW +: AW]);
  endfunction

  function automatic int unsigned m_read(int a, bit byp);
    if (!rst || a == 0) return 0;
    if (byp)
      for (int i = NW - 1; i >= 0; i--)
        if (we[i] && wa(i) == a) return wd(i);
    return mem[a];
  endfunction

  int hits [M];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < M; r++) begin mem[r] = 0; mbusy[r] = 0; end
      mcnt = 0;
    end else begin
      bit any_coll;
      any_coll = 0;
      for (int r = 0; r < M; r++) hits[r] = 0;
      for (int i = 0; i < NW; i++)
        if (we[i] && wa(i) != 0) begin
          mem[wa(i)]   = wd(i);
          mbusy[wa(i)] = 0;
          hits[wa(i)]++;
        end
      for (int r = 0; r < M; r++) if (hits[r] > 1) any_coll = 1;
      if (set_busy && busy_addr != 0) mbusy[busy_addr] = 1;
      if (any_coll && mcnt < 255) mcnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    for (int j = 0; j < NR; j++) begin
      chk($sformatf("rdata_byp[%0d]", j), rdata_b[j*N +: N], m_read(ra(j), 1'b1));
      chk($sformatf("rdata_old[%0d]", j), rdata_o[j*N +: N], m_read(ra(j), 1'b0));
      chk($sformatf("rbusy_byp[%0d]", j), 32'(rbusy_b[j]), 32'(rst ? mbusy[ra(j)] : 1'b0));
      chk($sformatf("rbusy_old[%0d]", j), 32'(rbusy_o[j]), 32'(rst ? mbusy[ra(j)] : 1'b0));
    end
    chk("coll_cnt_byp", 32'(coll_b), 32'(mcnt));
    chk("coll_cnt_old", 32'(coll_o), 32'(mcnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask
  task automatic settle();
    @(negedge clk); #1;
  endtask
  task automatic idle();
    we = '0; set_busy = 1'b0;
  endtask
  task automatic wr(input int p, input int a, input logic [31:0] d);
    we[p] = 1'b1; waddr[p*AW +: AW] = AW'(a); wdata[p*N +: N] = d;
  endtask
  task automatic rd(input int p, input int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  initial begin
    // Reset held: outputs zero regardless of address.
    repeat (2) @(posedge clk);
    #2; rd(0, 5); rd(1, 9); #1;
    chk("reset_rdata0", rdata_b[0 +: N], 32'd0);
    chk("reset_rbusy", 32'(rbusy_b), 32'd0);
    tick(); rst = 1'b1;

    // All registers read zero after reset.
    for (int a = 0; a < M; a++) begin
      tick(); rd(0, a); rd(1, M - 1 - a); settle();
      chk("post_reset_rd0", rdata_b[0 +: N], 32'd0);
      chk("post_reset_rd1", rdata_o[N +: N], 32'd0);
      chk("post_reset_busy", 32'(rbusy_o), 32'd0);
    end
    chk("post_reset_coll", 32'(coll_b), 32'd0);

    // Sequential fill through port 0.
    for (int i = 0; i < M; i++) begin
      tick(); idle(); wr(0, i, 32'((i + 2) * (i + 2)));
    end
    tick(); idle();
    for (int i = 0; i < M; i++) begin
      rd(0, i); settle();
      chk("fill_readback", rdata_o[0 +: N], (i == 0) ? 32'd0 : 32'((i + 2) * (i + 2)));
      tick();
    end

    // Collision: port 1 wins, counter saturates.
    tick(); idle(); wr(0, 7, 32'd5); wr(1, 7, 32'd9);
    tick(); idle(); rd(0, 7); settle();
    chk("coll_winner", rdata_o[0 +: N], 32'd9);
    chk("coll_cnt_one", 32'(coll_b), 32'd1);
    tick(); wr(0, 7, 32'd5); wr(1, 7, 32'd9);
    repeat (300) tick();
    idle(); settle();
    chk("coll_cnt_sat", 32'(coll_o), 32'd255);

    // Bypass vs read-old on reg 3 (holds 25 from the fill).
    tick(); idle(); rd(0, 3); wr(0, 3, 32'hAA); settle();
    chk("bypass_same_cycle", rdata_b[0 +: N], 32'hAA);
    chk("readold_same_cycle", rdata_o[0 +: N], 32'd25);
    tick(); idle(); settle();
    chk("readold_next_cycle", rdata_o[0 +: N], 32'hAA);

    // Scoreboard on reg 4.
    tick(); idle(); rd(1, 4); set_busy = 1'b1; busy_addr = 5'd4; settle();
    chk("busy_no_bypass", 32'(rbusy_b[1]), 32'd0);
    tick(); idle(); settle();
    chk("busy_set", 32'(rbusy_b[1]), 32'd1);
    tick(); set_busy = 1'b1; busy_addr = 5'd4; wr(0, 4, 32'd1);
    tick(); idle(); settle();
    chk("busy_set_wins", 32'(rbusy_o[1]), 32'd1);
    tick(); wr(0, 4, 32'd2);
    tick(); idle(); settle();
    chk("busy_cleared", 32'(rbusy_o[1]), 32'd0);
    tick(); set_busy = 1'b1; busy_addr = 5'd0;
    tick(); idle(); rd(1, 0); settle();
    chk("busy_reg0_never", 32'(rbusy_b[1]), 32'd0);

    // Reset pulsed mid-cycle with a write in flight.
    tick(); idle(); wr(0, 10, 32'd123); rd(0, 3);
    #1 rst = 1'b0;
    #1 chk("midrst_rdata", rdata_b[0 +: N], 32'd0);
    tick(); idle(); rst = 1'b1; rd(0, 10); rd(1, 3); settle();
    chk("midrst_write_lost", rdata_b[0 +: N], 32'd0);
    chk("midrst_reg3", rdata_o[N +: N], 32'd0);
    chk("midrst_coll", 32'(coll_b), 32'd0);

    // Randomized traffic checked by the per-cycle compare.
    for (int c = 0; c < 2000; c++) begin
      tick();
      we = NW'($urandom);
      waddr = NW*AW'($urandom);
      if ($urandom_range(3) == 0) waddr[AW +: AW] = waddr[0 +: AW];
      wdata = {$urandom, $urandom};
      raddr = NR*AW'($urandom);
      if ($urandom_range(1) == 0) raddr[0 +: AW] = waddr[0 +: AW];
      set_busy = ($urandom_range(2) == 0);
      busy_addr = AW'($urandom);
    end
    tick(); idle();
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp_reg_bank.md
MP_REG_BANK -- requirements
Module: mp_reg_bank

Interface
REQ-001 SHALL have parameter N, default 32, data width in bits.
REQ-002 SHALL have parameter M, default 32, register count; M >= 2, power of two.
REQ-003 SHALL have parameter NR, default 2, read-port count (1..4).
REQ-004 SHALL have parameter NW, default 2, write-port count (1..4).
REQ-005 SHALL have parameter BYPASS, default 1: 1 means write-first read, 0 means read-old.
REQ-006 SHALL have parameter ZERO_REG, default 1: 1 means register 0 is hardwired to zero.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port we, input, NW bits, per-port write enable.
REQ-010 SHALL have port waddr, input, NW*log2(M) bits, packed write addresses; port i occupies slice i.
REQ-011 SHALL have port wdata, input, NW*N bits, packed write data.
REQ-012 SHALL have port raddr, input, NR*log2(M) bits, packed read addresses.
REQ-013 SHALL have port rdata, output, NR*N bits, packed read data.
REQ-014 SHALL have port set_busy, input, 1 bit, request to mark register busy_addr pending.
REQ-015 SHALL have port busy_addr, input, log2(M) bits, register to mark pending.
REQ-016 SHALL have port rbusy, output, NR bits, pending flag of each read port's addressed register.
REQ-017 SHALL have port coll_cnt, output, 8 bits, saturating count of write-address collisions.

Function
REQ-018 SHALL write wdata[i] to register waddr[i] at the rising clk edge when we[i]=1.
REQ-019 SHALL resolve two or more enabled ports with the same waddr in one cycle so that the highest-indexed port wins.
REQ-020 SHALL increment coll_cnt by 1 in each cycle that has at least one collision, and SHALL saturate at 255 with no wrap.
REQ-021 SHALL make rdata combinational from raddr and register contents, with zero added clock latency.
REQ-022 SHALL, when BYPASS=1, return on rdata the same-cycle winning wdata for any enabled write to raddr.
REQ-023 SHALL, when BYPASS=0, return on rdata the pre-edge register value; the new value appears in the next cycle.
REQ-024 SHALL, when ZERO_REG=1, ignore writes to register 0, never count writes to register 0 as collisions, read 0 from register 0, never bypass register 0, and never set busy on register 0.
REQ-025 SHALL keep one busy bit per register (scoreboard).
REQ-026 SHALL set the busy bit of busy_addr at the edge when set_busy=1.
REQ-027 SHALL clear a register's busy bit at the edge on which any enabled write targets that register.
REQ-028 SHALL let set win when set and clear hit the same register in the same cycle, so that busy stays 1.
REQ-029 SHALL drive rbusy[j] combinationally from the busy bit of raddr[j], with no bypass of same-cycle set or clear.

Reset
REQ-030 SHALL, while rst=0, asynchronously clear all registers, all busy bits and coll_cnt to 0.
REQ-031 SHALL make rdata=0 and rbusy=0 on every port during reset, independent of raddr.
REQ-032 SHALL discard any write or set_busy in a cycle where rst is asserted mid-operation.
REQ-033 SHALL take effect on the first rising clk edge after rst deassertion.

Structure
REQ-034 SHALL place the default constants (N=32, M=32, NR=2, NW=2) and the address-width function in the shared package regbank_pkg.
REQ-035 SHALL implement write-port arbitration and collision detection in one sub-module, regbank_wr_arb, that produces per-register write enable and data.
REQ-036 SHALL instantiate regbank_wr_arb exactly once inside mp_reg_bank.

Verification
REQ-037 SHALL cover reset then reads of all 32 registers: every rdata=0, every rbusy=0, coll_cnt=0.
REQ-038 SHALL cover the sequential fill: write (i+2)^2 to reg i through port 0 for i=0..31, then read back; reg0=0 and reg i=(i+2)^2 for i>=1.
REQ-039 SHALL cover a collision: port0 writes 5->reg7 and port1 writes 9->reg7 in the same cycle; reg7=9 and coll_cnt=1; 300 such cycles leave coll_cnt=255.
REQ-040 SHALL cover bypass: BYPASS=1, raddr=3 with a write of 0xAA to reg3 returns 0xAA in the same cycle; BYPASS=0 returns the old value, then 0xAA one cycle later.
REQ-041 SHALL cover the scoreboard: set_busy reg4 gives rbusy=1 next cycle; a write to reg4 together with set_busy reg4 keeps busy=1; a write alone then gives busy=0.
REQ-042 SHALL cover reset mid-operation: rst pulsed low between edges while regs hold data; rdata=0 immediately, the in-flight write is lost, and state is 0 after release.
